// File: rtl/spi_master_if.sv
// Host command/response channel plus SPI pins for spi_master.
// SPI_MASTER_ABORT_EN adds the abort request and aborted strobe.
interface spi_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [9:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
`ifdef SPI_MASTER_ABORT_EN
   logic       abort;
   logic       aborted;
`endif

   modport master (
      input  cmd_valid,
      input  cmd_data,
      input  MISO,
`ifdef SPI_MASTER_ABORT_EN
      input  abort,
      output aborted,
`endif
      output cmd_ready,
      output rsp_valid,
      output rsp_data,
      output SS_n,
      output MOSI
   );

   modport slave (
      output cmd_valid,
      output cmd_data,
      output MISO,
`ifdef SPI_MASTER_ABORT_EN
      output abort,
      input  aborted,
`endif
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_data,
      input  SS_n,
      input  MOSI
   );
endinterface

// File: rtl/spi_master.sv
// SPI master: frames a 10-bit command MSB-first on SS_n/MOSI, one bit per clk, and
// captures an 8-bit MISO reply for rd-data. SPI_MASTER_ABORT_EN enables frame abort.
module spi_master #(
   parameter int unsigned TURN_CYC = 2,
   parameter int unsigned GAP_CYC  = 2
) (
   input logic          clk,
   input logic          rst,
   spi_master_if.master bus
);
   typedef enum logic [2:0] {StIdle, StChk, StShift, StTurn, StCapt, StGap} state_e;

   localparam logic [3:0] TurnLast = 4'(TURN_CYC - 1);
   localparam logic [3:0] GapLast  = 4'(GAP_CYC - 1);

   state_e     state_q;
   logic [9:0] cmd_q;
   logic [3:0] cnt_q;
   logic [7:0] sreg_q;
   logic       ss_n_q;
   logic       mosi_q;
   logic       ready_q;
   logic       rsp_valid_q;
   logic [7:0] rsp_data_q;
   logic       abort_hit;

`ifdef SPI_MASTER_ABORT_EN
   logic aborted_q;
   assign abort_hit   = bus.abort && (state_q inside {StChk, StShift, StTurn, StCapt});
   assign bus.aborted = aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   assign bus.cmd_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.SS_n      = ss_n_q;
   assign bus.MOSI      = mosi_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cmd_q       <= '0;
         cnt_q       <= '0;
         sreg_q      <= '0;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
`ifdef SPI_MASTER_ABORT_EN
         aborted_q   <= 1'b0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
         aborted_q   <= 1'b0;
`endif
         if (abort_hit) begin
            state_q <= StGap;
            cnt_q   <= '0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
            aborted_q <= 1'b1;
`endif
         end else begin
            case (state_q)
               StIdle: begin
                  ready_q <= 1'b1;
                  if (bus.cmd_valid && ready_q) begin
                     cmd_q   <= bus.cmd_data;
                     ready_q <= 1'b0;
                     ss_n_q  <= 1'b0;
                     mosi_q  <= bus.cmd_data[9];
                     state_q <= StChk;
                  end
               end
               // Check cycle repeats the MSB; SHIFT then sends all ten bits.
               StChk: begin
                  state_q <= StShift;
                  cnt_q   <= '0;
                  mosi_q  <= cmd_q[9];
               end
               StShift: begin
                  if (cnt_q == 4'd9) begin
                     cnt_q  <= '0;
                     mosi_q <= 1'b0;
                     if (cmd_q[9:8] == 2'b11) begin
                        state_q <= StTurn;
                     end else begin
                        state_q <= StGap;
                        ss_n_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q  <= cnt_q + 4'd1;
                     mosi_q <= cmd_q[4'd8 - cnt_q];
                  end
               end
               StTurn: begin
                  if (cnt_q == TurnLast) begin
                     cnt_q   <= '0;
                     state_q <= StCapt;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               StCapt: begin
                  sreg_q <= {sreg_q[6:0], bus.MISO};
                  if (cnt_q == 4'd7) begin
                     rsp_data_q  <= {sreg_q[6:0], bus.MISO};
                     rsp_valid_q <= 1'b1;
                     ss_n_q      <= 1'b1;
                     cnt_q       <= '0;
                     state_q     <= StGap;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               StGap: begin
                  if (cnt_q == GapLast) begin
                     cnt_q   <= '0;
                     ready_q <= 1'b1;
                     state_q <= StIdle;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with TURN_CYC=2, GAP_CYC=2; outputs sampled 1ns after posedge.
module tb_spi_master;
   localparam int TURN = 2;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   spi_master_if bus ();

   spi_master #(.TURN_CYC(TURN), .GAP_CYC(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [9:0] cmd);
      int n = 0;
      while (!bus.cmd_ready && n < 50) begin
         step();
         n++;
      end
      check("accept_ready", {31'b0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = cmd;
      step();
      bus.cmd_valid = 1'b0;
   endtask

   // Starts in CHK; drives MISO during CAPT cycles (frame index 11+TURN .. 18+TURN).
   task automatic collect(input logic [7:0] miso_bits, output int low,
                          output logic [10:0] seq, output logic tail_ok);
      int idx = 0;
      low     = 0;
      seq     = '0;
      tail_ok = 1'b1;
      while (bus.SS_n == 1'b0 && idx < 100) begin
         if (idx < 11) seq = {seq[9:0], bus.MOSI};
         else if (bus.MOSI !== 1'b0) tail_ok = 1'b0;
         if (idx >= 11 + TURN && idx < 19 + TURN) bus.MISO = miso_bits[18 + TURN - idx];
         else bus.MISO = 1'b0;
         low++;
         idx++;
         step();
      end
      bus.MISO = 1'b0;
   endtask

   task automatic finish_gap(output int gap, output int pulses, output logic [7:0] last);
      gap    = 0;
      pulses = 0;
      last   = '0;
      while (!bus.cmd_ready && gap < 40) begin
         if (bus.rsp_valid) begin
            pulses++;
            last = bus.rsp_data;
         end
         gap++;
         step();
      end
   endtask

   initial begin
      int          low, gap, pulses, hi, cnt;
      logic [10:0] seq;
      logic        tail_ok;
      logic [7:0]  last;

      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = '0;
      bus.MISO      = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
      bus.abort     = 1'b0;
`endif

      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_ss_n", {31'b0, bus.SS_n}, 32'd1);
         check("rst_mosi", {31'b0, bus.MOSI}, 32'd0);
         check("rst_ready", {31'b0, bus.cmd_ready}, 32'd0);
         check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      end
      rst = 1'b0;
      step();
      check("ready_after_rst", {31'b0, bus.cmd_ready}, 32'd1);
      check("rsp_data_rst", {24'b0, bus.rsp_data}, 32'h00);

      // Write-data frame 00_1010_0101
      send(10'h0A5);
      collect(8'h00, low, seq, tail_ok);
      check("wr_low", low, 11);
      check("wr_mosi", {21'b0, seq}, {21'b0, 11'b0_00_1010_0101});
      finish_gap(gap, pulses, last);
      check("wr_gap", gap, 2);
      check("wr_rsp_cnt", pulses, 0);

      // rd-data frame with MISO 1,0,1,1,0,0,1,0 -> B2
      send(10'h3C0);
      collect(8'hB2, low, seq, tail_ok);
      check("rd_low", low, 21);
      check("rd_mosi", {21'b0, seq}, {21'b0, 11'b1_11_1100_0000});
      check("rd_tail_zero", {31'b0, tail_ok}, 32'd1);
      finish_gap(gap, pulses, last);
      check("rd_gap", gap, 2);
      check("rd_rsp_cnt", pulses, 1);
      check("rd_rsp_data", {24'b0, last}, 32'hB2);
      check("rsp_data_hold", {24'b0, bus.rsp_data}, 32'hB2);

      // Back-to-back with cmd_valid held high
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 10'h155;
      step();
      check("b2b_first_chk", {31'b0, bus.SS_n}, 32'd0);
      bus.cmd_data = 10'h2AB;
      collect(8'h00, low, seq, tail_ok);
      check("b2b_low1", low, 11);
      check("b2b_mosi1", {21'b0, seq}, {21'b0, 11'b0_01_0101_0101});
      hi = 0;
      while (bus.SS_n && hi < 20) begin
         hi++;
         step();
      end
      check("b2b_spacing", hi, 3);
      bus.cmd_valid = 1'b0;
      collect(8'h00, low, seq, tail_ok);
      check("b2b_low2", low, 11);
      check("b2b_mosi2", {21'b0, seq}, {21'b0, 11'b1_10_1010_1011});
      finish_gap(gap, pulses, last);
      check("b2b_rsp_cnt", pulses, 0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (!bus.SS_n) cnt++;
         step();
      end
      check("b2b_no_dup", cnt, 0);

      // Reset during SHIFT bit 5 of an rd-data frame
      send(10'h3FF);
      for (int i = 0; i < 6; i++) step();
      check("rst_mid_low", {31'b0, bus.SS_n}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_ss_n", {31'b0, bus.SS_n}, 32'd1);
      check("rst_mid_rsp_data", {24'b0, bus.rsp_data}, 32'h00);
      pulses = 0;
      cnt    = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.rsp_valid) pulses++;
         if (!bus.SS_n) cnt++;
         step();
      end
      check("rst_mid_no_rsp", pulses, 0);
      check("rst_mid_ss_idle", cnt, 0);
      send(10'h012);
      collect(8'h00, low, seq, tail_ok);
      check("post_rst_low", low, 11);
      check("post_rst_mosi", {21'b0, seq}, {21'b0, 11'b0_00_0001_0010});
      finish_gap(gap, pulses, last);
      check("post_rst_gap", gap, 2);

`ifdef SPI_MASTER_ABORT_EN
      // Abort in the third CAPT cycle (frame index 15)
      send(10'h3C0);
      for (int i = 0; i < 15; i++) begin
         bus.MISO = 1'b1;
         step();
      end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort_ss_n", {31'b0, bus.SS_n}, 32'd1);
      check("abort_mosi", {31'b0, bus.MOSI}, 32'd0);
      check("abort_pulse", {31'b0, bus.aborted}, 32'd1);
      check("abort_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
      step();
      check("abort_pulse_end", {31'b0, bus.aborted}, 32'd0);
      finish_gap(gap, pulses, last);
      check("abort_rsp_cnt", pulses, 0);
      check("abort_rsp_data", {24'b0, bus.rsp_data}, 32'h00);
      bus.MISO  = 1'b0;
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort_idle_none", {31'b0, bus.aborted}, 32'd0);
      check("abort_idle_ready", {31'b0, bus.cmd_ready}, 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
